slv_reset_sequencer: RTL and testbench
======================================

SLV_RESET_SEQUENCER -- requirements
Module: slv_reset_sequencer

Interface
REQ-001 SHALL have parameter RstCycles, default 16: cycles slv_rst_o is held high; legal range 1..65535.
REQ-002 SHALL have parameter SettleCycles, default 4: cycles after slv_rst_o falls before clear; legal range 1..65535.
REQ-003 SHALL have parameter IsoTimeout, default 256: max cycles to wait for isolate_ack_i; legal range 1..65535.
REQ-004 SHALL have parameter SeqCntWidth, default 16: width of the shared phase counter.
REQ-005 SHALL have port clk_i, input, 1: single clock.
REQ-006 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_reset_req_i, input, 1: sticky reset request from the write guard.
REQ-008 SHALL have port rd_reset_req_i, input, 1: sticky reset request from the read guard.
REQ-009 SHALL have port isolate_ack_i, input, 1: AXI isolation stage reports the slave is isolated and drained.
REQ-010 SHALL have port isolate_o, output, 1: request to isolate the slave port.
REQ-011 SHALL have port slv_rst_o, output, 1: active-high reset to the monitored slave.
REQ-012 SHALL have port reset_clear_o, output, 1: one-cycle pulse to both guards' reset_clear_i.
REQ-013 SHALL have port busy_o, output, 1: the sequencer is not in IDLE.
REQ-014 SHALL have port cause_o, output, 2: latched {rd,wr} request bits of the last sequence.
REQ-015 SHALL have port iso_timeout_o, output, 1: sticky flag set when isolation timed out.
REQ-016 SHALL have port rst_count_o, output, 8: saturating count of completed sequences.

Function
REQ-017 SHALL implement FSM states IDLE, ISOLATE, RESET, SETTLE, CLEAR and WAIT_DROP.
REQ-018 In IDLE with (wr_reset_req_i | rd_reset_req_i) = 1, the FSM SHALL go to ISOLATE next cycle, latch cause_o from the request inputs, and load the counter to 0.
REQ-019 In ISOLATE, isolate_o SHALL be 1 and the counter SHALL increment each cycle.
REQ-020 ISOLATE SHALL leave for RESET when isolate_ack_i = 1, or when the counter reaches IsoTimeout-1; on timeout, iso_timeout_o SHALL set.
REQ-021 If ack and timeout coincide in the same cycle, ack SHALL win and iso_timeout_o SHALL NOT set.
REQ-022 In RESET, slv_rst_o SHALL be 1 for exactly RstCycles cycles, registered output, then the FSM SHALL go to SETTLE.
REQ-023 In SETTLE, slv_rst_o SHALL be 0 and isolate_o SHALL be 1 for SettleCycles cycles, then the FSM SHALL go to CLEAR.
REQ-024 CLEAR SHALL last one cycle with reset_clear_o = 1, then the FSM SHALL go to WAIT_DROP.
REQ-025 In WAIT_DROP, isolate_o SHALL stay 1 until both request inputs are 0.
REQ-026 On leaving WAIT_DROP, the FSM SHALL enter IDLE and rst_count_o SHALL increment, saturating at 255.
REQ-027 isolate_o SHALL be 1 in all states except IDLE; busy_o SHALL equal (state != IDLE).
REQ-028 Requests arriving after IDLE SHALL OR into cause_o only while in ISOLATE; from RESET onward they SHALL NOT retrigger the sequence.
REQ-029 If a request is still high 1 cycle after entering IDLE (re-asserted by a guard), a new sequence SHALL start per REQ-018.
REQ-030 All outputs SHALL be registered; latency from request to isolate_o = 1 SHALL be 1 cycle.
REQ-031 The phase counter SHALL be SeqCntWidth bits, reused across phases and zeroed on every state change; a compile-time assertion SHALL check that each parameter is < 2^SeqCntWidth.

Reset
REQ-032 While rst_i = 1, all outputs SHALL be 0 and the state SHALL be IDLE, taking effect asynchronously; iso_timeout_o and rst_count_o SHALL clear.
REQ-033 rst_i asserted mid-sequence SHALL abort immediately; the FSM SHALL NOT resume after release.

Structure
REQ-034 The state enum and the rst_count width constant SHALL reside in slv_pkg, alongside hs_cnt_t and the other guard types.
REQ-035 A sub-module seq_phase_counter SHALL provide load/enable/terminal-count; the FSM SHALL be in the top module.

Verification
REQ-036 Pulse wr_reset_req_i held high, ack at cycle 3 -> isolate_o at +1, slv_rst_o high 16 cycles, reset_clear_o one cycle, cause_o = 2'b01, rst_count_o = 1.
REQ-037 No ack, IsoTimeout = 8 -> RESET entered after 8 ISOLATE cycles, iso_timeout_o = 1.
REQ-038 Assert wr and rd requests simultaneously -> cause_o = 2'b11, a single sequence.
REQ-039 Requests held high 5 cycles after reset_clear_o -> remain in WAIT_DROP with isolate_o = 1, IDLE one cycle after both drop.
REQ-040 Assert rst_i during RESET -> slv_rst_o = 0 and isolate_o = 0 immediately, busy_o = 0.
REQ-041 Run 260 back-to-back sequences -> rst_count_o saturates at 255.

Source files
------------

// File: rtl/slv_pkg.sv
// -----------------------------------------------------------------------------
// slv_pkg
// Shared types and constants for the slave guard / reset sequencer slice.
//   hs_cnt_t       : handshake counter type used by the read/write guards
//   guard_err_e    : guard error classification
//   seq_state_e    : reset sequencer FSM state encoding
//   RstCountWidth  : width of the completed-sequence counter (rst_count_o)
//   sat_inc_rst_cnt: saturating increment for the completed-sequence counter
// -----------------------------------------------------------------------------
package slv_pkg;

  // Guard-side types
  localparam int HsCntWidth = 16;
  typedef logic [HsCntWidth-1:0] hs_cnt_t;

  typedef enum logic [1:0] {
    GUARD_OK        = 2'd0,
    GUARD_TIMEOUT   = 2'd1,
    GUARD_PROTO_ERR = 2'd2
  } guard_err_e;

  // Reset sequencer types
  localparam int RstCountWidth = 8;
  typedef logic [RstCountWidth-1:0] rst_count_t;
  localparam rst_count_t RstCountMax = '1;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_ISOLATE   = 3'd1,
    SEQ_RESET     = 3'd2,
    SEQ_SETTLE    = 3'd3,
    SEQ_CLEAR     = 3'd4,
    SEQ_WAIT_DROP = 3'd5
  } seq_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic rst_count_t sat_inc_rst_cnt(input rst_count_t value);
    if (value == RstCountMax) begin
      return value;
    end
    return value + rst_count_t'(1);
  endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// -----------------------------------------------------------------------------
// seq_phase_counter
// Phase counter shared by all timed phases of the reset sequencer.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (clears the count)
//   load_i : zero the count (has priority over en_i)
//   en_i   : advance the count by one
//   last_i : terminal value of the current phase
//   tc_o   : count currently equals last_i
// -----------------------------------------------------------------------------
module seq_phase_counter
  import slv_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic             tc_o
);

  logic [Width-1:0] count_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (load_i) begin
      count_reg <= '0;
    end else if (en_i) begin
      count_reg <= count_reg + Width'(1);
    end
  end

  assign tc_o = (count_reg == last_i);

endmodule

// File: rtl/slv_reset_sequencer.sv
// -----------------------------------------------------------------------------
// slv_reset_sequencer
// Isolates a monitored AXI slave, resets it, lets it settle, then pulses a
// clear to both guards and waits for their requests to drop.
//   clk_i          : clock
//   rst_i          : asynchronous active-high reset
//   wr_reset_req_i : sticky reset request from the write guard
//   rd_reset_req_i : sticky reset request from the read guard
//   isolate_ack_i  : isolation stage reports slave isolated and drained
//   isolate_o      : isolate the slave port (all states except IDLE)
//   slv_rst_o      : active-high reset to the slave (RESET state)
//   reset_clear_o  : one-cycle pulse to the guards (CLEAR state)
//   busy_o         : sequencer not idle
//   cause_o        : latched {rd,wr} request bits of the last sequence
//   iso_timeout_o  : sticky, isolation ack never arrived in time
//   rst_count_o    : saturating count of completed sequences
// -----------------------------------------------------------------------------
module slv_reset_sequencer
  import slv_pkg::*;
#(
  parameter int RstCycles    = 16,
  parameter int SettleCycles = 4,
  parameter int IsoTimeout   = 256,
  parameter int SeqCntWidth  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_reset_req_i,
  input  logic                     rd_reset_req_i,
  input  logic                     isolate_ack_i,
  output logic                     isolate_o,
  output logic                     slv_rst_o,
  output logic                     reset_clear_o,
  output logic                     busy_o,
  output logic [1:0]               cause_o,
  output logic                     iso_timeout_o,
  output logic [RstCountWidth-1:0] rst_count_o
);

  // Every phase length must be non-zero and representable by the counter.
  if (SeqCntWidth < 1) begin : g_bad_width
    $error("slv_reset_sequencer: SeqCntWidth must be at least 1");
  end
  if (RstCycles < 1 || (RstCycles >> SeqCntWidth) != 0) begin : g_bad_rst
    $error("slv_reset_sequencer: RstCycles out of range for SeqCntWidth");
  end
  if (SettleCycles < 1 || (SettleCycles >> SeqCntWidth) != 0) begin : g_bad_settle
    $error("slv_reset_sequencer: SettleCycles out of range for SeqCntWidth");
  end
  if (IsoTimeout < 1 || (IsoTimeout >> SeqCntWidth) != 0) begin : g_bad_iso
    $error("slv_reset_sequencer: IsoTimeout out of range for SeqCntWidth");
  end

  // The counter starts at 0 on phase entry, so an N-cycle phase ends at N-1.
  localparam logic [SeqCntWidth-1:0] IsoLast    = SeqCntWidth'(IsoTimeout - 1);
  localparam logic [SeqCntWidth-1:0] RstLast    = SeqCntWidth'(RstCycles - 1);
  localparam logic [SeqCntWidth-1:0] SettleLast = SeqCntWidth'(SettleCycles - 1);

  seq_state_e state_reg, state_next;

  logic [1:0]             req_vec;
  logic                   any_req;
  logic                   iso_timeout_set;
  logic                   phase_load;
  logic                   phase_en;
  logic                   phase_tc;
  logic [SeqCntWidth-1:0] phase_last;

  logic                   isolate_reg;
  logic                   slv_rst_reg;
  logic                   reset_clear_reg;
  logic                   busy_reg;
  logic [1:0]             cause_reg, cause_next;
  logic                   iso_timeout_reg;
  rst_count_t             rst_count_reg, rst_count_next;

  assign req_vec = {rd_reset_req_i, wr_reset_req_i};
  assign any_req = |req_vec;

  // ---------------------------------------------------------------------------
  // Phase counter: zeroed on every state change, runs in the timed phases.
  // ---------------------------------------------------------------------------
  assign phase_load = (state_next != state_reg);
  assign phase_en   = (state_reg == SEQ_ISOLATE) || (state_reg == SEQ_RESET) ||
                      (state_reg == SEQ_SETTLE);

  always_comb begin
    phase_last = '0;
    case (state_reg)
      SEQ_ISOLATE: phase_last = IsoLast;
      SEQ_RESET:   phase_last = RstLast;
      SEQ_SETTLE:  phase_last = SettleLast;
      default:     phase_last = '0;
    endcase
  end

  seq_phase_counter #(
    .Width (SeqCntWidth)
  ) u_phase_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (phase_load),
    .en_i   (phase_en),
    .last_i (phase_last),
    .tc_o   (phase_tc)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    iso_timeout_set = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        if (any_req) begin
          state_next = SEQ_ISOLATE;
        end
      end
      SEQ_ISOLATE: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (isolate_ack_i) begin
          state_next = SEQ_RESET;
        end else if (phase_tc) begin
          state_next      = SEQ_RESET;
          iso_timeout_set = 1'b1;
        end
      end
      SEQ_RESET: begin
        if (phase_tc) begin
          state_next = SEQ_SETTLE;
        end
      end
      SEQ_SETTLE: begin
        if (phase_tc) begin
          state_next = SEQ_CLEAR;
        end
      end
      SEQ_CLEAR: begin
        state_next = SEQ_WAIT_DROP;
      end
      SEQ_WAIT_DROP: begin
        if (!any_req) begin
          state_next = SEQ_IDLE;
        end
      end
      default: begin
        state_next = SEQ_IDLE;
      end
    endcase
  end

  // Cause bits: captured fresh on sequence start, accumulate only while
  // isolating, frozen from RESET onward.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cause
    assign cause_next[gi] =
      (state_reg == SEQ_IDLE && state_next == SEQ_ISOLATE) ? req_vec[gi] :
      (state_reg == SEQ_ISOLATE) ? (cause_reg[gi] | req_vec[gi]) :
      cause_reg[gi];
  end

  assign rst_count_next = (state_reg == SEQ_WAIT_DROP && state_next == SEQ_IDLE) ?
                          sat_inc_rst_cnt(rst_count_reg) : rst_count_reg;

  // ---------------------------------------------------------------------------
  // State and output registers. Outputs are decoded from the next state so
  // they change on the same edge as the state itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= SEQ_IDLE;
      isolate_reg     <= 1'b0;
      slv_rst_reg     <= 1'b0;
      reset_clear_reg <= 1'b0;
      busy_reg        <= 1'b0;
      cause_reg       <= 2'b00;
      iso_timeout_reg <= 1'b0;
      rst_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      isolate_reg     <= (state_next != SEQ_IDLE);
      slv_rst_reg     <= (state_next == SEQ_RESET);
      reset_clear_reg <= (state_next == SEQ_CLEAR);
      busy_reg        <= (state_next != SEQ_IDLE);
      cause_reg       <= cause_next;
      iso_timeout_reg <= iso_timeout_reg | iso_timeout_set;
      rst_count_reg   <= rst_count_next;
    end
  end

  assign isolate_o     = isolate_reg;
  assign slv_rst_o     = slv_rst_reg;
  assign reset_clear_o = reset_clear_reg;
  assign busy_o        = busy_reg;
  assign cause_o       = cause_reg;
  assign iso_timeout_o = iso_timeout_reg;
  assign rst_count_o   = rst_count_reg;

endmodule

// File: tb/tb_slv_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_slv_reset_sequencer
// Directed scenarios for slv_reset_sequencer with RstCycles=16, SettleCycles=4,
// IsoTimeout=8. Inputs are driven and outputs sampled 1 time unit after each
// rising clock edge.
// -----------------------------------------------------------------------------
module tb_slv_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic       rd_req;
  logic       ack;
  logic       isolate_o;
  logic       slv_rst_o;
  logic       reset_clear_o;
  logic       busy_o;
  logic [1:0] cause_o;
  logic       iso_timeout_o;
  logic [7:0] rst_count_o;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  slv_reset_sequencer #(
    .RstCycles    (16),
    .SettleCycles (4),
    .IsoTimeout   (8),
    .SeqCntWidth  (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_reset_req_i (wr_req),
    .rd_reset_req_i (rd_req),
    .isolate_ack_i  (ack),
    .isolate_o      (isolate_o),
    .slv_rst_o      (slv_rst_o),
    .reset_clear_o  (reset_clear_o),
    .busy_o         (busy_o),
    .cause_o        (cause_o),
    .iso_timeout_o  (iso_timeout_o),
    .rst_count_o    (rst_count_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (reset_clear_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; ack = 1'b0;
    repeat (3) tick();
    total++;
    if ({isolate_o, slv_rst_o, reset_clear_o, busy_o, cause_o, iso_timeout_o, rst_count_o} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want all zero",
               {isolate_o, slv_rst_o, reset_clear_o, busy_o, cause_o, iso_timeout_o, rst_count_o});
    end
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: busy got %b want 0", busy_o);
    end
    $display("test_reset: outputs=%b", {isolate_o, slv_rst_o, reset_clear_o, busy_o});
  endtask

  task automatic test_basic();
    int n;
    bit settle_iso;
    bit ok;
    wr_req = 1'b1;
    tick();
    total++;
    if (isolate_o !== 1'b1 || slv_rst_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_isolate_latency: isolate=%b slv_rst=%b want 1/0", isolate_o, slv_rst_o);
    end
    total++;
    if (cause_o !== 2'b01) begin
      bad++;
      $display("FAIL basic_cause: got %b want 01", cause_o);
    end
    tick();
    ack = 1'b1;
    tick();
    n = 0;
    while (slv_rst_o && n < 100) begin
      n++;
      tick();
    end
    ack = 1'b0;
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL basic_rst_width: got %0d cycles want 16", n);
    end
    n = 0;
    settle_iso = 1'b1;
    while (!reset_clear_o && n < 50) begin
      if (!isolate_o || slv_rst_o) settle_iso = 1'b0;
      n++;
      tick();
    end
    total++;
    if (n != 4 || !settle_iso) begin
      bad++;
      $display("FAIL basic_settle: got %0d cycles iso_ok=%b want 4 cycles iso_ok=1", n, settle_iso);
    end
    wr_req = 1'b0;
    tick();
    total++;
    if (reset_clear_o !== 1'b0 || isolate_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_clear_pulse: clear=%b isolate=%b want 0/1", reset_clear_o, isolate_o);
    end
    tick();
    exp_count++;
    total++;
    if (busy_o !== 1'b0 || isolate_o !== 1'b0 || rst_count_o !== 8'(exp_count) || cause_o !== 2'b01) begin
      bad++;
      $display("FAIL basic_done: busy=%b iso=%b count=%0d cause=%b want 0/0/%0d/01",
               busy_o, isolate_o, rst_count_o, cause_o, exp_count);
    end
    ok = 1'b1;
    $display("test_basic: count=%0d cause=%b", rst_count_o, cause_o);
  endtask

  task automatic test_timeout();
    int n;
    bit early;
    bit ok;
    wr_req = 1'b1; ack = 1'b0;
    tick();
    n = 0;
    early = 1'b0;
    while (isolate_o && !slv_rst_o && n < 50) begin
      if (iso_timeout_o) early = 1'b1;
      n++;
      tick();
    end
    total++;
    if (n != 8 || slv_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_isolate_len: got %0d cycles slv_rst=%b want 8/1", n, slv_rst_o);
    end
    total++;
    if (iso_timeout_o !== 1'b1 || early) begin
      bad++;
      $display("FAIL timeout_flag: got %b early=%b want 1 early=0", iso_timeout_o, early);
    end
    wait_clear(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout_clear_wait: got no clear want clear pulse");
    end
    wr_req = 1'b0;
    wait_idle(ok);
    exp_count++;
    total++;
    if (!ok || rst_count_o !== 8'(exp_count)) begin
      bad++;
      $display("FAIL timeout_done: idle=%b count=%0d want 1/%0d", ok, rst_count_o, exp_count);
    end
    $display("test_timeout: iso_timeout=%b count=%0d", iso_timeout_o, rst_count_o);
  endtask

  task automatic test_simultaneous();
    bit ok;
    bit stayed_idle;
    wr_req = 1'b1; rd_req = 1'b1; ack = 1'b1;
    tick();
    total++;
    if (cause_o !== 2'b11 || isolate_o !== 1'b1) begin
      bad++;
      $display("FAIL simul_cause: cause=%b isolate=%b want 11/1", cause_o, isolate_o);
    end
    tick();
    total++;
    if (slv_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL simul_ack_reset: slv_rst got %b want 1", slv_rst_o);
    end
    ack = 1'b0;
    wait_clear(ok);
    wr_req = 1'b0; rd_req = 1'b0;
    wait_idle(ok);
    exp_count++;
    stayed_idle = ok;
    repeat (5) begin
      tick();
      if (busy_o) stayed_idle = 1'b0;
    end
    total++;
    if (!stayed_idle || rst_count_o !== 8'(exp_count)) begin
      bad++;
      $display("FAIL simul_single_seq: idle=%b count=%0d want 1/%0d", stayed_idle, rst_count_o, exp_count);
    end
    $display("test_simultaneous: cause=%b count=%0d", cause_o, rst_count_o);
  endtask

  task automatic test_late_request();
    bit ok;
    // Request from the second guard while isolating: ORs into cause.
    wr_req = 1'b1; ack = 1'b0;
    tick();
    rd_req = 1'b1;
    tick();
    total++;
    if (cause_o !== 2'b11) begin
      bad++;
      $display("FAIL late_or_in_isolate: cause got %b want 11", cause_o);
    end
    rd_req = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_clear(ok);
    wr_req = 1'b0;
    wait_idle(ok);
    exp_count++;
    // Request from the second guard during RESET: ignored for cause.
    wr_req = 1'b1; ack = 1'b1;
    tick();
    tick();
    ack = 1'b0; rd_req = 1'b1;
    tick();
    tick();
    total++;
    if (cause_o !== 2'b01 || slv_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL late_in_reset: cause=%b slv_rst=%b want 01/1", cause_o, slv_rst_o);
    end
    wr_req = 1'b0;
    wait_clear(ok);
    tick();
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL late_hold_rd: busy got %b want 1", busy_o);
    end
    rd_req = 1'b0;
    wait_idle(ok);
    exp_count++;
    repeat (3) tick();
    total++;
    if (busy_o !== 1'b0 || rst_count_o !== 8'(exp_count)) begin
      bad++;
      $display("FAIL late_no_retrigger: busy=%b count=%0d want 0/%0d", busy_o, rst_count_o, exp_count);
    end
    $display("test_late_request: cause=%b count=%0d", cause_o, rst_count_o);
  endtask

  task automatic test_wait_drop();
    bit ok;
    bit held;
    wr_req = 1'b1; ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    wait_clear(ok);
    held = 1'b1;
    repeat (5) begin
      tick();
      if (!isolate_o || !busy_o) held = 1'b0;
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL wait_drop_hold: isolate/busy dropped want held 5 cycles");
    end
    wr_req = 1'b0;
    tick();
    exp_count++;
    total++;
    if (busy_o !== 1'b0 || isolate_o !== 1'b0 || rst_count_o !== 8'(exp_count)) begin
      bad++;
      $display("FAIL wait_drop_idle: busy=%b iso=%b count=%0d want 0/0/%0d",
               busy_o, isolate_o, rst_count_o, exp_count);
    end
    // Guard re-asserts right after IDLE: a fresh sequence starts.
    wr_req = 1'b1;
    tick();
    total++;
    if (busy_o !== 1'b1 || isolate_o !== 1'b1) begin
      bad++;
      $display("FAIL retrigger: busy=%b iso=%b want 1/1", busy_o, isolate_o);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_clear(ok);
    wr_req = 1'b0;
    wait_idle(ok);
    exp_count++;
    total++;
    if (rst_count_o !== 8'(exp_count)) begin
      bad++;
      $display("FAIL retrigger_count: got %0d want %0d", rst_count_o, exp_count);
    end
    $display("test_wait_drop: count=%0d", rst_count_o);
  endtask

  task automatic test_abort();
    bit stayed_idle;
    wr_req = 1'b1; ack = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (slv_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_in_reset: slv_rst got %b want 1", slv_rst_o);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (slv_rst_o !== 1'b0 || isolate_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: slv_rst=%b iso=%b busy=%b want 0/0/0", slv_rst_o, isolate_o, busy_o);
    end
    total++;
    if (iso_timeout_o !== 1'b0 || rst_count_o !== 8'd0 || cause_o !== 2'b00) begin
      bad++;
      $display("FAIL abort_clears: timeout=%b count=%0d cause=%b want 0/0/00",
               iso_timeout_o, rst_count_o, cause_o);
    end
    exp_count = 0;
    tick();
    wr_req = 1'b0; ack = 1'b0;
    tick();
    rst = 1'b0;
    stayed_idle = 1'b1;
    repeat (5) begin
      tick();
      if (busy_o || slv_rst_o) stayed_idle = 1'b0;
    end
    total++;
    if (!stayed_idle) begin
      bad++;
      $display("FAIL abort_no_resume: busy=%b slv_rst=%b want 0/0", busy_o, slv_rst_o);
    end
    $display("test_abort: busy=%b count=%0d", busy_o, rst_count_o);
  endtask

  task automatic test_tie();
    bit ok;
    wr_req = 1'b1; ack = 1'b0;
    tick();
    repeat (7) tick();
    total++;
    if (slv_rst_o !== 1'b0 || isolate_o !== 1'b1) begin
      bad++;
      $display("FAIL tie_still_isolating: slv_rst=%b iso=%b want 0/1", slv_rst_o, isolate_o);
    end
    ack = 1'b1;
    tick();
    total++;
    if (slv_rst_o !== 1'b1 || iso_timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL tie_ack_wins: slv_rst=%b timeout=%b want 1/0", slv_rst_o, iso_timeout_o);
    end
    ack = 1'b0;
    wait_clear(ok);
    wr_req = 1'b0;
    wait_idle(ok);
    exp_count++;
    $display("test_tie: iso_timeout=%b", iso_timeout_o);
  endtask

  task automatic test_saturate();
    bit ok_c;
    bit ok_i;
    int expv;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 260; i++) begin
      wr_req = 1'b1; ack = 1'b1;
      tick();
      wait_clear(ok_c);
      wr_req = 1'b0; ack = 1'b0;
      wait_idle(ok_i);
      expv = (i + 1 > 255) ? 255 : i + 1;
      total++;
      if (!ok_c || !ok_i || rst_count_o !== 8'(expv)) begin
        bad++;
        $display("FAIL saturate_seq%0d: clear=%b idle=%b count=%0d want 1/1/%0d",
                 i, ok_c, ok_i, rst_count_o, expv);
      end
      $display("seq %0d: rst_count=%0d", i, rst_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_simultaneous();
    test_late_request();
    test_wait_drop();
    test_abort();
    test_tie();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
